sha_256_scheduler: RTL and testbench

SHA_256_SCHEDULER -- requirements
Module: sha_256_scheduler

---
 rtl/sha_256_scheduler.sv | 140 ++++++++++++++
 tb/tb_sha_256_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_256_scheduler.sv
// sha_256_scheduler
// -----------------------------------------------------------------------------
// Shares one sha_256 core between N_REQ requesters. An idle scheduler picks a
// requester round-robin, loads its message into the core and pulses core_rst.
// It then waits LATENCY cycles and captures the digest. The digest is
// presented together with the owning requester's index.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   req          per-requester hash request (level, sampled only in IDLE)
//   msg_in       requester i message at [i*MSG_SIZE +: MSG_SIZE]
//   ack          one-hot grant pulse, high during the LOAD cycle
//   busy         core allocated (state other than IDLE)
//   hash_out     last captured digest
//   hash_valid   one-cycle pulse marking hash_out as new (DONE cycle)
//   hash_id      index of the requester owning hash_out
//   core_message message driven to the core, stable from LOAD through DONE
//   core_rst     core restart: high in LOAD and while rst is high
//   core_hashed  digest coming back from the core
// -----------------------------------------------------------------------------
module sha_256_scheduler #(
    parameter int N_REQ    = 4,
    parameter int MSG_SIZE = 208,
    parameter int LATENCY  = 72
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*MSG_SIZE-1:0]   msg_in,
    output logic [N_REQ-1:0]            ack,
    output logic                        busy,
    output logic [255:0]                hash_out,
    output logic                        hash_valid,
    output logic [$clog2(N_REQ)-1:0]    hash_id,
    output logic [MSG_SIZE-1:0]         core_message,
    output logic                        core_rst,
    input  logic [255:0]                core_hashed
);

    localparam int IDW  = $clog2(N_REQ);
    // One extra value keeps the width >= 1 even when LATENCY == 1.
    localparam int CNTW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [IDW-1:0]      grant_reg;
    logic [IDW-1:0]      last_grant_reg;
    logic [CNTW-1:0]     cnt_reg;
    logic [MSG_SIZE-1:0] core_message_reg;
    logic [255:0]        hash_out_reg;
    logic [IDW-1:0]      hash_id_reg;

    logic [IDW-1:0]      win_idx;
    logic                win_found;
    logic                run_last;

    // Unpack the flat message bus into one word per requester.
    logic [MSG_SIZE-1:0] msg_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign msg_arr[gi] = msg_in[gi*MSG_SIZE +: MSG_SIZE];
            // ack is decoded from the registered grant, so it can only be
            // high in LOAD and drops as soon as rst forces IDLE.
            assign ack[gi]     = (state_reg == LOAD) && (grant_reg == IDW'(gi));
        end
    endgenerate

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(last_grant_reg) + k) % N_REQ;
            cand = IDW'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign run_last = (cnt_reg == CNTW'(LATENCY - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_found) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (run_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            grant_reg        <= '0;
            last_grant_reg   <= IDW'(N_REQ - 1);
            cnt_reg          <= '0;
            core_message_reg <= '0;
            hash_out_reg     <= '0;
            hash_id_reg      <= '0;
        end else begin
            state_reg <= state_next;
            // Counts only in RUN, so it reads 0 in LOAD and in the first RUN cycle.
            cnt_reg   <= (state_reg == RUN) ? cnt_reg + 1'b1 : '0;
            if (state_reg == IDLE && win_found) begin
                grant_reg        <= win_idx;
                last_grant_reg   <= win_idx;
                core_message_reg <= msg_arr[win_idx];
            end
            // Capture on the final RUN edge so the digest is visible in DONE.
            if (state_reg == RUN && run_last) begin
                hash_out_reg <= core_hashed;
                hash_id_reg  <= grant_reg;
            end
        end
    end

    assign busy         = (state_reg != IDLE);
    assign hash_valid   = (state_reg == DONE);
    assign hash_out     = hash_out_reg;
    assign hash_id      = hash_id_reg;
    assign core_message = core_message_reg;
    assign core_rst     = rst || (state_reg == LOAD);

endmodule

// File: tb/tb_sha_256_scheduler.sv
// Testbench for sha_256_scheduler: table-driven single jobs plus hand-written
// sequences for contention, late request, reset mid-run and withdrawal.
// A stand-in core returns a known digest only LATENCY cycles after core_rst.
module tb_sha_256_scheduler;

    localparam int N_REQ    = 4;
    localparam int MSG_SIZE = 24;
    localparam int LATENCY  = 72;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] JUNK = {8{32'hbad0bad0}};

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*MSG_SIZE-1:0] msg_in;
    logic [N_REQ-1:0]          ack;
    logic                      busy;
    logic [255:0]              hash_out;
    logic                      hash_valid;
    logic [1:0]                hash_id;
    logic [MSG_SIZE-1:0]       core_message;
    logic                      core_rst;
    logic [255:0]              core_hashed;

    sha_256_scheduler #(
        .N_REQ   (N_REQ),
        .MSG_SIZE(MSG_SIZE),
        .LATENCY (LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .msg_in      (msg_in),
        .ack         (ack),
        .busy        (busy),
        .hash_out    (hash_out),
        .hash_valid  (hash_valid),
        .hash_id     (hash_id),
        .core_message(core_message),
        .core_rst    (core_rst),
        .core_hashed (core_hashed)
    );

    always #5 clk = ~clk;

    // Stand-in core: digest valid only once LATENCY cycles have elapsed
    // since core_rst released; before that it returns junk.
    int fc_cnt = 0;
    always @(posedge clk) begin
        if (core_rst)          fc_cnt <= 0;
        else if (fc_cnt < 1000) fc_cnt <= fc_cnt + 1;
    end
    assign core_hashed = (fc_cnt >= LATENCY - 1)
                       ? ((core_message == 24'h616263) ? ABC_DIGEST : {232'b0, core_message})
                       : JUNK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for an ack pulse; n is cycles waited (bounded).
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < 20);
    endtask

    // Wait for hash_valid; counts cycles and stray ack/core_rst pulses seen.
    task automatic wait_valid(output int n, output int stray);
        n     = 0;
        stray = 0;
        do begin
            @(negedge clk);
            n++;
            if (ack != '0 || core_rst) stray++;
        end while (!hash_valid && n < 200);
    endtask

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   exp_ack;
        logic [1:0]   exp_id;
        logic [255:0] exp_hash;
    } vec_t;

    vec_t vecs[6];

    task automatic run_job(input int k, input vec_t v);
        int n, stray;
        string nm;
        nm  = $sformatf("job%0d", k);
        req = v.req;
        wait_ack(n);
        check({nm, " ack"}, ack, v.exp_ack);
        check({nm, " ack_delay"}, n, 1);
        check({nm, " core_rst_load"}, core_rst, 1);
        check({nm, " core_message"}, core_message, msg_in[v.exp_id*MSG_SIZE +: MSG_SIZE]);
        req = '0;
        wait_valid(n, stray);
        check({nm, " valid_delay"}, n, LATENCY + 1);
        check({nm, " stray"}, stray, 0);
        check({nm, " hash_id"}, hash_id, v.exp_id);
        check({nm, " hash_out"}, hash_out, v.exp_hash);
        @(negedge clk);
        check({nm, " valid_one_cycle"}, hash_valid, 0);
        check({nm, " idle_after"}, busy, 0);
        $display("job %0d: req=%b ack=%b id=%0d hash=%h", k, v.req, v.exp_ack, hash_id, hash_out);
    endtask

    initial begin
        int n, stray, cnt;
        time t_prev, t_now;
        logic [3:0] exp_a;

        vecs[0] = '{4'b0001, 4'b0001, 2'd0, ABC_DIGEST};
        vecs[1] = '{4'b0011, 4'b0010, 2'd1, 256'h111111};
        vecs[2] = '{4'b0011, 4'b0001, 2'd0, ABC_DIGEST};
        vecs[3] = '{4'b1100, 4'b0100, 2'd2, 256'h222222};
        vecs[4] = '{4'b0101, 4'b0001, 2'd0, ABC_DIGEST};
        vecs[5] = '{4'b1000, 4'b1000, 2'd3, 256'h333333};

        rst    = 1'b1;
        req    = '0;
        msg_in = {24'h333333, 24'h222222, 24'h111111, 24'h616263};
        repeat (3) @(negedge clk);
        check("rst ack", ack, 0);
        check("rst busy", busy, 0);
        check("rst hash_valid", hash_valid, 0);
        check("rst hash_id", hash_id, 0);
        check("rst hash_out", hash_out, 0);
        check("rst core_message", core_message, 0);
        check("rst core_rst", core_rst, 1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst core_rst", core_rst, 0);
        check("post_rst busy", busy, 0);

        // Table-driven single jobs; rotation state carries between entries.
        for (int k = 0; k < 6; k++) run_job(k, vecs[k]);

        // Contention: all requests held, grants rotate 0,1,2,3,0 every 75 cycles.
        req    = 4'b1111;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack(n);
            t_now = $time;
            exp_a = 4'b0001 << (k % 4);
            check($sformatf("cont%0d ack", k), ack, exp_a);
            if (k > 0) check($sformatf("cont%0d spacing", k), (t_now - t_prev) / 10, 75);
            t_prev = t_now;
            if (k == 4) req = '0;
            wait_valid(n, stray);
            check($sformatf("cont%0d hash_id", k), hash_id, k % 4);
            $display("contention grant %0d: ack=%b id=%0d", k, exp_a, hash_id);
        end
        @(negedge clk);
        check("cont idle", busy, 0);

        // Late request: req[2] raised mid-RUN is only granted after DONE+1.
        req = 4'b0001;
        wait_ack(n);
        check("late ack0", ack, 4'b0001);
        req = '0;
        repeat (10) @(negedge clk);
        req = 4'b0100;
        wait_valid(n, stray);
        check("late stray", stray, 0);
        check("late hash_id0", hash_id, 0);
        @(negedge clk);
        check("late idle_ack", ack, 0);
        @(negedge clk);
        check("late ack2", ack, 4'b0100);
        req = '0;
        wait_valid(n, stray);
        check("late hash_id2", hash_id, 2);
        check("late hash2", hash_out, 256'h222222);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (hash_valid || busy) cnt++;
        end
        check("late no_dup", cnt, 0);
        $display("late request: ids 0 then 2");

        // Reset at RUN counter 30 aborts the job without reporting it.
        req = 4'b0001;
        wait_ack(n);
        check("abort ack", ack, 4'b0001);
        req = '0;
        repeat (31) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort ack_rst", ack, 0);
        check("abort hash_id", hash_id, 0);
        check("abort hash_out", hash_out, 0);
        check("abort core_message", core_message, 0);
        check("abort core_rst", core_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (LATENCY + 10) begin
            @(negedge clk);
            if (hash_valid || busy || ack != '0) cnt++;
        end
        check("abort silent", cnt, 0);
        run_job(6, '{4'b0010, 4'b0010, 2'd1, 256'h111111});
        $display("reset mid-run: aborted job silent, req1 regranted");

        // Withdrawal: req[1] pulsed only while busy is never acknowledged.
        req = 4'b0001;
        wait_ack(n);
        check("wd ack0", ack, 4'b0001);
        req = '0;
        repeat (5) @(negedge clk);
        req = 4'b0010;
        repeat (5) @(negedge clk);
        req = '0;
        cnt = 0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            if (ack[1]) cnt++;
        end while (!hash_valid && n < 200);
        check("wd hash_id", hash_id, 0);
        repeat (10) begin
            @(negedge clk);
            if (ack != '0 || busy) cnt++;
        end
        check("wd no_ack1", cnt, 0);
        $display("withdrawal: req1 pulse ignored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
